rv32i_mem_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between the IF stage (fetch port) and the MEM stage (load/store port).
- Picks one requester per cycle and drives the memory address, control and write data for it.
- Memory read data is registered inside the memory, so it returns one cycle after the access. The arbiter tracks which port owns that in-flight read and routes the data back to it.
- A streak counter lets data accesses win by default, while guaranteeing that fetch is never starved.

---
 rtl/rv32i_mem_arbiter.sv | 60 ++++++
 tb/tb_rv32i_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between the fetch and load/store ports,
// data-first with a bounded streak so fetch is never starved; routes registered read data back.
module rv32i_mem_arbiter #(
    parameter int MAX_D_STREAK = 3,
    parameter int STREAK_W     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    owner_t              owner, owner_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                force_if;
    always_comb begin
        force_if   = if_req && streak == STREAK_MAX;
        if_gnt     = !reset && if_req && (!d_req || force_if);
        d_gnt      = !reset && d_req && !force_if;
        mem_en     = if_gnt || d_gnt;
        mem_we     = d_gnt && d_we;
        mem_be     = if_gnt ? 4'hF : d_gnt ? d_be : 4'h0;
        mem_addr   = if_gnt ? if_addr : d_gnt ? d_addr : 30'h0;
        mem_wdata  = d_gnt ? d_wdata : 32'h0;
        streak_nxt = (d_gnt && if_req) ? ((streak == STREAK_MAX) ? streak : streak + 1'b1) : '0;
        owner_nxt  = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
        // a read still in flight when reset arrives must not surface
        if_rvalid  = !reset && owner == OWN_IF;
        d_rvalid   = !reset && owner == OWN_D;
        if_rdata   = if_rvalid ? mem_rdata : 32'h0;
        d_rdata    = d_rvalid ? mem_rdata : 32'h0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
            owner  <= OWN_NONE;
        end else begin
            streak <= streak_nxt;
            owner  <= owner_nxt;
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: randomized and directed stimulus, reference grant model and
// a response scoreboard checked by an independent monitor.
module tb_rv32i_mem_arbiter;
    localparam int MAXS = 3;
    logic        clk = 0, reset = 1;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [29:0] if_addr = 0, d_addr = 0;
    logic [3:0]  d_be = 0;
    logic [31:0] d_wdata = 0, mem_rdata = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;

    rv32i_mem_arbiter #(.MAX_D_STREAK(MAXS), .STREAK_W(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // memory stub: registered read data, garbage on non-read cycles
    function automatic logic [31:0] rd_of(input logic [29:0] a);
        return (a == 30'h0) ? 32'h0000_0013 : ({a, 2'b10} ^ 32'h5A5A_C3C3);
    endfunction
    always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? rd_of(mem_addr) : $urandom;

    typedef struct packed {logic is_d; logic [31:0] data; int due;} exp_t;
    exp_t q[$];
    int   consec = 0;
    bit   if_cons = 0, d_cons = 0;

    // reference model: decide the grant from the spec rules, check the memory drive, queue reads
    always @(negedge clk) begin
        bit e_if, e_d;
        if (reset) begin
            q.delete();
            consec  = 0;
            if_cons = 0;
            d_cons  = 0;
            chk({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid} == 5'b0, "reset_outputs",
                {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}, 0);
        end else begin
            e_if = if_req && (!d_req || consec >= MAXS);
            e_d  = d_req && !e_if;
            chk({if_gnt, d_gnt, mem_en, mem_we} == {e_if, e_d, e_if || e_d, e_d && d_we}, "grant",
                {if_gnt, d_gnt, mem_en, mem_we}, {e_if, e_d, e_if || e_d, e_d && d_we});
            if (e_if)
                chk({mem_be, mem_addr} == {4'hF, if_addr}, "fetch_drive", {mem_be, mem_addr}, {4'hF, if_addr});
            if (e_d)
                chk({mem_be, mem_addr, mem_wdata} == {d_be, d_addr, d_wdata}, "data_drive",
                    {mem_be, mem_addr, mem_wdata}, {d_be, d_addr, d_wdata});
            if (e_if) q.push_back('{1'b0, rd_of(if_addr), cyc + 1});
            else if (e_d && !d_we) q.push_back('{1'b1, rd_of(d_addr), cyc + 1});
            consec  = (e_d && if_req) ? consec + 1 : 0;
            if_cons = e_if;
            d_cons  = e_d;
        end
    end

    // monitor: every rvalid must match the oldest due entry, and every due entry must appear
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (if_rvalid && d_rvalid) chk(0, "both_rvalid", 2'b11, 2'b01);
        else if (if_rvalid || d_rvalid) begin
            if (q.size() == 0 || q[0].due != cyc) chk(0, "spurious_rvalid", {if_rvalid, d_rvalid}, 0);
            else begin
                e = q.pop_front();
                chk(d_rvalid == e.is_d, "rvalid_port", d_rvalid, e.is_d);
                chk((d_rvalid ? d_rdata : if_rdata) == e.data, "rdata",
                    d_rvalid ? d_rdata : if_rdata, e.data);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk(0, "missing_rvalid", 0, {e.is_d, 1'b1});
        end
        chk((if_rvalid || if_rdata == 0) && (d_rvalid || d_rdata == 0), "rdata_gating",
            {if_rdata, d_rdata}, 0);
    end

    task automatic drive(input logic ir, input logic [29:0] ia, input logic dr, input logic dw,
                         input logic [3:0] be, input logic [29:0] da, input logic [31:0] wd);
        @(posedge clk);
        #1;
        {if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata} = {ir, ia, dr, dw, be, da, wd};
    endtask

    initial begin
        logic [7:0] pat;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        drive(1, 30'h0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk(if_rvalid && if_rdata == 32'h13, "first_fetch", if_rdata, 32'h13);
        drive(1, 30'h8, 1, 0, 4'hF, 30'h100, 0);
        @(negedge clk);
        chk({if_gnt, d_gnt} == 2'b01, "data_priority", {if_gnt, d_gnt}, 2'b01);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk({if_rvalid, d_rvalid} == 2'b01, "data_priority_resp", {if_rvalid, d_rvalid}, 2'b01);
        for (int i = 0; i < 8; i++) begin
            drive(1, 30'h20, 1, 0, 4'hF, 30'h200, 0);
            @(negedge clk);
            pat[i] = if_gnt;
        end
        chk(pat == 8'b1000_1000, "starvation_pattern", pat, 8'b1000_1000);
        drive(0, 0, 1, 1, 4'b0011, 30'h40, 32'hDEADBEEF);
        @(negedge clk);
        chk({mem_we, mem_be, mem_wdata} == {1'b1, 4'b0011, 32'hDEADBEEF}, "store",
            {mem_we, mem_be, mem_wdata}, {1'b1, 4'b0011, 32'hDEADBEEF});
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk({if_rvalid, d_rvalid} == 2'b00, "store_no_rvalid", {if_rvalid, d_rvalid}, 0);
        drive(1, 30'h3FFF_FFFF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        repeat (2) begin
            @(negedge clk);
            chk(!if_rvalid, "reset_mid_read", if_rvalid, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            drive(i % 2 == 1, 30'(i), i % 2 == 0, 0, 4'hF, 30'(i + 100), 0);
            @(negedge clk);
            if (i > 0) chk(if_rvalid ^ d_rvalid, "b2b_no_dead", {if_rvalid, d_rvalid}, 2'b01);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom % 200) == 0;
            if (!if_req || if_cons) begin
                if_req  = ($urandom % 4) != 0;
                if_addr = 30'($urandom);
            end
            if (!d_req || d_cons) begin
                d_req   = ($urandom % 3) != 0;
                d_we    = 1'($urandom);
                d_be    = 4'($urandom);
                d_addr  = 30'($urandom);
                d_wdata = $urandom;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3;
        chk(q.size() == 0, "queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
